// File: rtl/frame_streamer_if.sv
// Pixel-stream source interface: buffer write port, stream control, raster output.
// Pure wiring, no latency of its own.
// Backpressure is the hold input; there is no ready/credit return on the pixel path.
interface frame_streamer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32
);
   localparam int ADDR_W = $clog2(IMG_WIDTH * IMG_HEIGHT);
   localparam int XW     = $clog2(IMG_WIDTH);
   localparam int YW     = $clog2(IMG_HEIGHT);

   logic                  wr_en;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  start;
   logic                  hold;
   logic                  frame_start;
   logic [DATA_WIDTH-1:0] pixel_out;
   logic                  pixel_valid;
   logic [XW-1:0]         x_pos;
   logic [YW-1:0]         y_pos;
   logic                  busy;
   logic                  done;

   // streamer side: it sources the pixel stream
   modport master (
      input  wr_en, wr_addr, wr_data, start, hold,
      output frame_start, pixel_out, pixel_valid, x_pos, y_pos, busy, done
   );

   // controller / consumer side
   modport slave (
      output wr_en, wr_addr, wr_data, start, hold,
      input  frame_start, pixel_out, pixel_valid, x_pos, y_pos, busy, done
   );
endinterface

// File: rtl/frame_streamer.sv
// Frame buffer that replays one IMG_WIDTH x IMG_HEIGHT frame in raster order on start.
// Latency: first pixel_valid 3 cycles after the start edge (SOF, PREP, pixel 0).
// Backpressure: hold freezes the stream (pixel_valid=0, position kept); ignored in SOF/PREP/GAP.
module frame_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32,
   parameter int LINE_GAP   = 0
) (
   input  logic             clk,
   input  logic             rst,
   frame_streamer_if.master bus
);
   localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
   localparam int ADDR_W = $clog2(NPIX);
   localparam int AW1    = ADDR_W + 1;
   localparam int XW     = $clog2(IMG_WIDTH);
   localparam int YW     = $clog2(IMG_HEIGHT);
   localparam int GAP_W  = (LINE_GAP > 0) ? $clog2(LINE_GAP + 1) : 1;

   typedef enum logic [2:0] {IDLE, SOF, PREP, STREAM, GAP} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] mem [NPIX];
   logic [ADDR_W-1:0]     idx;
   logic [XW-1:0]         col;
   logic [YW-1:0]         row;
   logic [GAP_W-1:0]      gap_cnt;
   logic                  last_sent;
   logic                  wr_ok;
   logic                  emit;

   logic                  frame_start_q;
   logic [DATA_WIDTH-1:0] pixel_q;
   logic                  valid_q;
   logic [XW-1:0]         x_q;
   logic [YW-1:0]         y_q;
   logic                  busy_q;
   logic                  done_q;

   assign bus.frame_start = frame_start_q;
   assign bus.pixel_out   = pixel_q;
   assign bus.pixel_valid = valid_q;
   assign bus.x_pos       = x_q;
   assign bus.y_pos       = y_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

   // write acceptance and "present the next pixel on this edge" decode
   always_comb begin
      wr_ok = (state == IDLE) && bus.wr_en && ({1'b0, bus.wr_addr} < AW1'(NPIX));
      emit  = 1'b0;
      case (state)
         PREP:    emit = 1'b1;
         STREAM:  emit = !bus.hold && !last_sent;
         GAP:     emit = (gap_cnt == GAP_W'(LINE_GAP));
         default: emit = 1'b0;
      endcase
   end

   // frame buffer write port; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
   end

   // sequencer: state, raster position and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         col           <= '0;
         row           <= '0;
         gap_cnt       <= '0;
         last_sent     <= 1'b0;
         frame_start_q <= 1'b0;
         pixel_q       <= '0;
         valid_q       <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         frame_start_q <= 1'b0;
         done_q        <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state         <= SOF;
                  busy_q        <= 1'b1;
                  frame_start_q <= 1'b1;
                  idx           <= '0;
                  col           <= '0;
                  row           <= '0;
                  last_sent     <= 1'b0;
               end
            end
            SOF:  state <= PREP;
            PREP: ;  // pixel 0 is issued by the emit path below
            STREAM: begin
               if (last_sent) begin
                  // last pixel was on the bus this cycle: close the frame
                  valid_q   <= 1'b0;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  last_sent <= 1'b0;
                  state     <= IDLE;
               end else if (bus.hold) begin
                  valid_q <= 1'b0;
               end
            end
            GAP: begin
               if (!emit) begin
                  valid_q <= 1'b0;
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (emit) begin
            pixel_q <= mem[idx];
            valid_q <= 1'b1;
            x_q     <= col;
            y_q     <= row;
            state   <= STREAM;
            if (idx == ADDR_W'(NPIX - 1)) begin
               last_sent <= 1'b1;
            end else begin
               idx <= idx + 1'b1;
               if (col == XW'(IMG_WIDTH - 1)) begin
                  col <= '0;
                  row <= row + 1'b1;
                  if (LINE_GAP > 0) begin
                     state   <= GAP;
                     gap_cnt <= '0;
                  end
               end else begin
                  col <= col + 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer: 32x32 no-gap instance and 4x4 LINE_GAP=2 instance.
// Stimulus pushes expected pixels into per-instance queues; negedge monitors pop and compare.
// Frame timing is checked from cycle stamps the monitors record.
module tb_frame_streamer;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   // cycle stamp: number of rising edges so far, stable at the falling edge
   always @(posedge clk) cyc <= cyc + 1;

   frame_streamer_if #(.DATA_WIDTH(8), .IMG_WIDTH(32), .IMG_HEIGHT(32)) bi ();
   frame_streamer_if #(.DATA_WIDTH(8), .IMG_WIDTH(4),  .IMG_HEIGHT(4))  si ();

   frame_streamer #(.DATA_WIDTH(8), .IMG_WIDTH(32), .IMG_HEIGHT(32), .LINE_GAP(0))
      dut_b (.clk(clk), .rst(rst), .bus(bi));
   frame_streamer #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .LINE_GAP(2))
      dut_s (.clk(clk), .rst(rst), .bus(si));

   logic [7:0]  big_img   [1024];
   logic [7:0]  small_img [16];
   logic [23:0] q_big[$];
   logic [23:0] q_small[$];
   int fs_big[$], done_big[$], fs_small[$], done_small[$], vs_small[$];
   int vcnt_big, first_v_big, last_v_big, busy_big, busy_small;
   logic [23:0] exp_b, act_b, exp_s, act_s;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // scoreboard monitor for the 32x32 instance
   always @(negedge clk) begin
      if (bi.frame_start) fs_big.push_back(cyc);
      if (bi.done) done_big.push_back(cyc);
      if (bi.busy) busy_big++;
      if (bi.pixel_valid) begin
         vcnt_big++;
         if (first_v_big < 0) first_v_big = cyc;
         last_v_big = cyc;
         act_b = {bi.pixel_out, 8'(bi.x_pos), 8'(bi.y_pos)};
         n_checks++;
         if (q_big.size() == 0) begin
            n_fail++;
            $display("FAIL big_pixel: got %h expected no pixel", act_b);
         end else begin
            exp_b = q_big.pop_front();
            if (act_b !== exp_b) begin
               n_fail++;
               $display("FAIL big_pixel: got {pix,x,y}=%h expected %h at cycle %0d", act_b, exp_b, cyc);
            end
         end
      end
   end

   // scoreboard monitor for the 4x4 gapped instance
   always @(negedge clk) begin
      if (si.frame_start) fs_small.push_back(cyc);
      if (si.done) done_small.push_back(cyc);
      if (si.busy) busy_small++;
      if (si.pixel_valid) begin
         vs_small.push_back(cyc);
         act_s = {si.pixel_out, 8'(si.x_pos), 8'(si.y_pos)};
         n_checks++;
         if (q_small.size() == 0) begin
            n_fail++;
            $display("FAIL small_pixel: got %h expected no pixel", act_s);
         end else begin
            exp_s = q_small.pop_front();
            if (act_s !== exp_s) begin
               n_fail++;
               $display("FAIL small_pixel: got {pix,x,y}=%h expected %h at cycle %0d", act_s, exp_s, cyc);
            end
         end
      end
   end

   task automatic clr_big();
      fs_big.delete();
      done_big.delete();
      vcnt_big = 0;
      first_v_big = -1;
      last_v_big = 0;
      busy_big = 0;
   endtask

   task automatic push_big();
      for (int i = 0; i < 1024; i++) q_big.push_back({big_img[i], 8'(i % 32), 8'(i / 32)});
   endtask

   // drive a one-cycle start from a falling edge; s = stamp of the accepting edge
   task automatic start_big(output int s);
      s = cyc + 1;
      bi.start = 1'b1;
      @(negedge clk);
      bi.start = 1'b0;
   endtask

   task automatic wait_big_done(input int n, input int budget);
      for (int k = 0; k < budget && done_big.size() < n; k++) @(negedge clk);
      chk("big_done_reached", 32'(done_big.size() >= n), 32'd1);
   endtask

   task automatic wait_big_pix(input int x, input int y, input int budget);
      for (int k = 0; k < budget && !(bi.pixel_valid && 32'(bi.x_pos) == x && 32'(bi.y_pos) == y); k++)
         @(negedge clk);
      chk("big_pixel_reached", 32'(bi.pixel_valid && 32'(bi.x_pos) == x && 32'(bi.y_pos) == y), 32'd1);
   endtask

   task automatic big_frame_chk(input string name, input int s, input int extra);
      chk({name, "_sof_cycle"},   32'(fs_big[0]),   32'(s));
      chk({name, "_first_valid"}, 32'(first_v_big), 32'(s + 2));
      chk({name, "_last_valid"},  32'(last_v_big),  32'(s + 1 + 1024 + extra));
      chk({name, "_done_cycle"},  32'(done_big[0]), 32'(s + 2 + 1024 + extra));
      chk({name, "_valid_count"}, 32'(vcnt_big),    32'd1024);
      chk({name, "_busy_cycles"}, 32'(busy_big),    32'(1026 + extra));
      chk({name, "_queue_empty"}, 32'(q_big.size()), 32'd0);
   endtask

   int s;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bi.wr_en = 0; bi.wr_addr = '0; bi.wr_data = '0; bi.start = 0; bi.hold = 0;
      si.wr_en = 0; si.wr_addr = '0; si.wr_data = '0; si.start = 0; si.hold = 0;
      clr_big();
      busy_small = 0;
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_frame_start", 32'(bi.frame_start), 32'd0);
      chk("rst_pixel_valid", 32'(bi.pixel_valid), 32'd0);
      chk("rst_busy",        32'(bi.busy),        32'd0);
      chk("rst_done",        32'(bi.done),        32'd0);
      chk("rst_pixel_out",   32'(bi.pixel_out),   32'd0);
      chk("rst_xy",          32'({bi.x_pos, bi.y_pos}), 32'd0);
      chk("rst_small_outs",  32'({si.frame_start, si.pixel_valid, si.busy, si.done,
                                  si.pixel_out, si.x_pos, si.y_pos}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // load both buffers in IDLE
      for (int i = 0; i < 1024; i++) begin
         big_img[i] = 8'((i + 1) % 256);
         bi.wr_en = 1'b1; bi.wr_addr = 10'(i); bi.wr_data = big_img[i];
         if (i < 16) begin
            small_img[i] = 8'(i + 1);
            si.wr_en = 1'b1; si.wr_addr = 4'(i); si.wr_data = small_img[i];
         end else begin
            si.wr_en = 1'b0;
         end
         @(negedge clk);
      end
      bi.wr_en = 1'b0;
      si.wr_en = 1'b0;
      @(negedge clk);

      // full frame, no stall
      clr_big(); push_big();
      start_big(s);
      wait_big_done(1, 1100);
      big_frame_chk("plain", s, 0);
      @(negedge clk);

      // 4x4 with two gap cycles after every row but the last
      fs_small.delete(); done_small.delete(); vs_small.delete(); busy_small = 0;
      for (int i = 0; i < 16; i++) q_small.push_back({small_img[i], 8'(i % 4), 8'(i / 4)});
      s = cyc + 1;
      si.start = 1'b1;
      @(negedge clk);
      si.start = 1'b0;
      for (int k = 0; k < 60 && done_small.size() < 1; k++) @(negedge clk);
      chk("small_sof_cycle", 32'(fs_small[0]), 32'(s));
      chk("small_valid_count", 32'(vs_small.size()), 32'd16);
      for (int i = 0; i < 16; i++)
         chk($sformatf("small_valid_cycle_%0d", i), 32'(vs_small[i]), 32'(s + 2 + i + 2 * (i / 4)));
      chk("small_done_cycle", 32'(done_small[0]), 32'(s + 24));
      chk("small_busy_cycles", 32'(busy_small), 32'd24);
      @(negedge clk);

      // hold for 5 cycles while (10,3) is on the bus
      clr_big(); push_big();
      start_big(s);
      wait_big_pix(10, 3, 200);
      bi.hold = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_frozen", 32'({bi.pixel_valid, bi.pixel_out, bi.x_pos, bi.y_pos}),
             32'({1'b0, 8'd107, 5'd10, 5'd3}));
      end
      bi.hold = 1'b0;
      wait_big_done(1, 1100);
      big_frame_chk("hold", s, 5);
      @(negedge clk);

      // start and buffer write while busy are both ignored
      clr_big(); push_big();
      start_big(s);
      repeat (10) @(negedge clk);
      bi.start = 1'b1; bi.wr_en = 1'b1; bi.wr_addr = '0; bi.wr_data = 8'hFF;
      @(negedge clk);
      bi.start = 1'b0; bi.wr_en = 1'b0;
      wait_big_done(1, 1100);
      big_frame_chk("busy_start", s, 0);
      chk("busy_start_no_restart", 32'(fs_big.size()), 32'd1);
      @(negedge clk);

      // reset at pixel 500 (x=20, y=15); the next frame must still start with addr 0 = 1
      clr_big(); push_big();
      start_big(s);
      wait_big_pix(20, 15, 700);
      #2 rst = 1'b1;
      #1;
      chk("abort_outputs_zero", 32'({bi.frame_start, bi.pixel_valid, bi.busy, bi.done,
                                     bi.pixel_out, bi.x_pos, bi.y_pos}), 32'd0);
      chk("abort_pixels_left", 32'(q_big.size()), 32'd523);
      q_big.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_no_done", 32'(done_big.size()), 32'd0);
      chk("abort_idle_outputs", 32'({bi.pixel_valid, bi.busy}), 32'd0);

      // restart from (0,0); hold during SOF and PREP has no effect
      clr_big(); push_big();
      s = cyc + 1;
      bi.start = 1'b1;
      @(negedge clk);
      bi.start = 1'b0;
      bi.hold = 1'b1;
      repeat (2) @(negedge clk);
      bi.hold = 1'b0;
      wait_big_done(1, 1100);
      big_frame_chk("after_abort", s, 0);
      @(negedge clk);

      // start held high: back-to-back frames, period W*H+3
      clr_big(); push_big(); push_big(); push_big();
      s = cyc + 1;
      bi.start = 1'b1;
      for (int k = 0; k < 3200 && fs_big.size() < 3; k++) @(negedge clk);
      bi.start = 1'b0;
      wait_big_done(3, 1200);
      chk("b2b_sof0", 32'(fs_big[0]), 32'(s));
      chk("b2b_sof1", 32'(fs_big[1]), 32'(s + 1027));
      chk("b2b_sof2", 32'(fs_big[2]), 32'(s + 2054));
      chk("b2b_done0", 32'(done_big[0]), 32'(s + 1026));
      chk("b2b_done1", 32'(done_big[1]), 32'(s + 2053));
      chk("b2b_done2", 32'(done_big[2]), 32'(s + 3080));
      chk("b2b_valid_count", 32'(vcnt_big), 32'd3072);
      chk("b2b_frames", 32'(fs_big.size()), 32'd3);
      repeat (3) @(negedge clk);

      chk("big_queue_drained", 32'(q_big.size()), 32'd0);
      chk("small_queue_drained", 32'(q_small.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
Transmit end of the pixel-stream interface consumed by the sliding-window generator. Holds one IMG_WIDTH x IMG_HEIGHT frame in an internal buffer loaded through a write port. On a start command it emits the frame in raster order using the same frame_start / pixel_in / pixel_valid protocol the window block expects. Used as the feature-map source in front of the window/conv pipeline and as the stimulus engine in system benches.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_WIDTH, 32, pixels per row
IMG_HEIGHT, 32, rows per frame
LINE_GAP, 0, idle cycles (pixel_valid=0) inserted after each row except the last
ADDR_W, $clog2(IMG_WIDTH*IMG_HEIGHT), localparam, buffer address width

Ports:
clk  in  1  single clock; all logic on its rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  buffer write strobe
wr_addr  in  ADDR_W  linear address, row*IMG_WIDTH+col
wr_data  in  DATA_WIDTH  pixel to store
start  in  1  request to stream the frame; sampled only in IDLE
hold  in  1  downstream stall; freezes streaming while high
frame_start  out  1  one-cycle start-of-frame pulse
pixel_out  out  DATA_WIDTH  pixel data; drives the window block's pixel_in
pixel_valid  out  1  pixel_out qualifier
x_pos  out  $clog2(IMG_WIDTH)  column of the pixel currently presented
y_pos  out  $clog2(IMG_HEIGHT)  row of the pixel currently presented
busy  out  1  high from start acceptance until done
done  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset is asynchronous and active-high. One clock, clk. Reset forces state IDLE and drives all outputs to 0: frame_start, pixel_out, pixel_valid, x_pos, y_pos, busy and done. Buffer contents are not cleared.
- Buffer: IMG_WIDTH*IMG_HEIGHT x DATA_WIDTH, written synchronously.
  - A write is accepted only in IDLE, when wr_en=1 and wr_addr < IMG_WIDTH*IMG_HEIGHT.
  - Writes while busy, and out-of-range writes, are silently dropped.
- All outputs are registered.
- State machine: IDLE -> SOF -> PREP -> STREAM <-> GAP -> IDLE.
  - IDLE: when start=1 at the edge, go to SOF and set busy=1.
  - SOF: frame_start=1 for exactly this one cycle. Go to PREP.
  - PREP: one idle cycle with frame_start=0 and pixel_valid=0. Go to STREAM.
  - STREAM, each edge with hold=0:
    - Register pixel_out = buf[idx], pixel_valid=1, x_pos/y_pos = coordinates of idx.
    - Advance idx.
    - At end of row: if the row is not the last and LINE_GAP>0, enter GAP.
  - STREAM, edge with hold=1: pixel_valid=0; idx, pixel_out, x_pos and y_pos hold their values.
  - GAP: count LINE_GAP cycles with pixel_valid=0, then return to STREAM. hold is ignored in GAP.
  - After the last pixel (idx = IMG_WIDTH*IMG_HEIGHT-1) has been presented:
    - Next edge: pixel_valid=0, done=1 (one cycle), busy=0, state IDLE.
    - A start sampled in that done cycle is accepted, giving back-to-back frames with no extra gap.
- Latency:
  - first pixel_valid occurs 3 cycles after the start edge (SOF, PREP, then first pixel);
  - frame length with no hold = 2 + W*H + (H-1)*LINE_GAP cycles from SOF to the last pixel.
- Pixel ordering: row-major. x increments 0..IMG_WIDTH-1; y increments when x wraps.
- start while busy: ignored, with no effect on the current frame.
- hold asserted in SOF or PREP: ignored; hold only stalls STREAM.
- Reset mid-frame: immediate abort, outputs 0, no done pulse. A subsequent start streams the frame from pixel (0,0).

Test Plan:
- 32x32 frame loaded with buf[i] = (i+1) mod 256, then start -> frame_start 1 cycle; next cycle idle; then 1024 consecutive pixel_valid cycles carrying 1,2,...,255,0,1,...; x/y sweep raster order; done 1 cycle after last pixel; busy high throughout.
- hold=1 for 5 cycles mid-row at (x=10, y=3) -> pixel_valid=0 for those cycles; pixel_out, x_pos and y_pos stay frozen; streaming resumes at (11,3) with no pixel lost or duplicated; total valid count 1024.
- 4x4 instance with LINE_GAP=2 and buffer 1..16 -> exactly 2 invalid cycles after pixels 4, 8 and 12, none after 16; frame spans 2+16+6 cycles.
- While busy: start pulse plus wr_en writing 0xFF to addr 0 -> no restart, frame unchanged; after done, readback stream shows the original addr-0 value.
- rst pulsed at pixel 500 -> all outputs 0 asynchronously, no done; a new start streams from pixel (0,0) with the buffer intact.
- start held high continuously -> frames repeat with done coinciding with the next acceptance edge; frame_start every 2+W*H+1 cycles.
